if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 118 +++++++++++
 tb/tb_if_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit driving the IF/ID register: owns the PC, runs the imem
// handshake, buffers one instruction and redirects on taken branches.
// Optional perf counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] PC,
    output logic [31:0] Instruction
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic {
        FETCH    = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_instr_q, slot_instr_d;

    logic drain;
    logic can_fill;
    logic fill;

    assign drain    = valid_q & ~freeze;
    assign can_fill = ~valid_q | drain;

    // A request is only raised when the slot can take the response, so a
    // pending request can never be dropped by a later freeze.
    assign imem_req  = rst & (state_q == FETCH) & can_fill & ~Branch_taken;
    assign imem_addr = pc_q;
    assign fill      = imem_req & imem_ready;

    assign valid_out   = valid_q;
    assign PC          = slot_pc_q;
    assign Instruction = slot_instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;

        if (Branch_taken) begin
            pc_d         = Branch_Address;
            valid_d      = 1'b0;
            slot_instr_d = '0;
            state_d      = REDIRECT;
        end else if (state_q == REDIRECT) begin
            state_d = FETCH;
        end else if (fill) begin
            pc_d         = pc_q + PC_STEP;
            slot_pc_d    = pc_q + PC_STEP;
            slot_instr_d = imem_rdata;
            valid_d      = 1'b1;
        end else if (drain) begin
            valid_d      = 1'b0;
            slot_instr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (fill) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (valid_q && freeze) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, streaming, wait states, freeze,
// branch/redirect and PC wrap; checks perf counters when IF_FETCH_PERF_EN is set.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] PC;
    logic [31:0] Instruction;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks;
    int failures;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .Branch_taken   (Branch_taken),
        .Branch_Address (Branch_Address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .valid_out      (valid_out),
        .PC             (PC),
        .Instruction    (Instruction)
`ifdef IF_FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".PC"}, PC, pc);
        check({tag, ".Instr"}, Instruction, ins);
    endtask

    task automatic req(input string tag, input logic r, input logic [31:0] addr);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
        if (r) check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        freeze = 1'b0;
        Branch_taken = 1'b0;
        Branch_Address = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;

        #2;
        slot("reset", 1'b0, 32'h0, 32'h0);
        req("reset", 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        req("release", 1'b1, 32'h0);
        // Asynchronous reset while a request is outstanding
        rst = 1'b0;
        #1;
        req("midreset", 1'b0, 32'h0);
        slot("midreset", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        req("rerelease", 1'b1, 32'h0);

        // Streaming with zero-wait memory
        imem_ready = 1'b1;
        imem_rdata = 32'h2001_0005;
        tick();
        slot("stream0", 1'b1, 32'h4, 32'h2001_0005);
        req("stream0", 1'b1, 32'h4);
        imem_rdata = 32'h2002_0007;
        tick();
        slot("stream1", 1'b1, 32'h8, 32'h2002_0007);
        req("stream1", 1'b1, 32'h8);

        // Freeze two cycles with slot PC=8
        freeze = 1'b1;
        imem_rdata = 32'h1111_1111;
        #1;
        req("frz0", 1'b0, 32'h0);
        tick();
        slot("frz1", 1'b1, 32'h8, 32'h2002_0007);
        req("frz1", 1'b0, 32'h0);
        tick();
        slot("frz2", 1'b1, 32'h8, 32'h2002_0007);
        freeze = 1'b0;
        imem_rdata = 32'h2003_0009;
        #1;
        req("unfrz", 1'b1, 32'h8);
        tick();
        slot("drainfill", 1'b1, 32'hC, 32'h2003_0009);

        // Wait states at 0x10
        imem_rdata = 32'h2004_000B;
        tick();
        slot("fill10", 1'b1, 32'h10, 32'h2004_000B);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req("wait", 1'b1, 32'h10);
            tick();
            slot("waitslot", 1'b0, 32'h10, 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h2005_000D;
        req("wait3", 1'b1, 32'h10);
        tick();
        slot("fill14", 1'b1, 32'h14, 32'h2005_000D);

        // Branch while a response arrives
        imem_rdata = 32'hDEAD_BEEF;
        Branch_taken = 1'b1;
        Branch_Address = 32'h40;
        #1;
        req("brcycle", 1'b0, 32'h0);
        tick();
        Branch_taken = 1'b0;
        slot("brdrop", 1'b0, 32'h14, 32'h0);
        req("redirect", 1'b0, 32'h0);
        tick();
        req("after_redir", 1'b1, 32'h40);
        imem_rdata = 32'h2006_0001;
        tick();
        slot("fill44", 1'b1, 32'h44, 32'h2006_0001);

        // Branch again during REDIRECT
        imem_ready = 1'b0;
        Branch_taken = 1'b1;
        Branch_Address = 32'h80;
        tick();
        Branch_Address = 32'h100;
        tick();
        Branch_taken = 1'b0;
        req("redir2", 1'b0, 32'h0);
        tick();
        req("tgt100", 1'b1, 32'h100);
        imem_ready = 1'b1;
        imem_rdata = 32'h2007_0003;
        tick();
        slot("fill104", 1'b1, 32'h104, 32'h2007_0003);

        // PC wrap at top of address space
        imem_ready = 1'b0;
        Branch_taken = 1'b1;
        Branch_Address = 32'hFFFF_FFFC;
        tick();
        Branch_taken = 1'b0;
        tick();
        req("tgtwrap", 1'b1, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        tick();
        slot("wrap", 1'b1, 32'h0, 32'h2008_0005);
        req("wrap", 1'b1, 32'h0);

        // One more frozen cycle with the slot occupied
        imem_ready = 1'b0;
        freeze = 1'b1;
        tick();
        slot("frz3", 1'b1, 32'h0, 32'h2008_0005);
        freeze = 1'b0;

`ifdef IF_FETCH_PERF_EN
        check("fetch_count", fetch_count, 32'd8);
        check("stall_count", stall_count, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
